// File: rtl/uart_rx_deserializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deserializer_if
//  Description : Serial line input and received-byte outputs of the UART
//                receive deserializer, bundled for the SoC bus side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_deserializer_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_err;
  logic       parity_err;

  // Deserializer side: consumes the serial line, produces the byte and flags.
  modport slave (
    input  rx_in,
    output data_out,
    output rx_valid,
    output rx_busy,
    output framing_err,
    output parity_err
  );

  // Line driver / register-file side.
  modport master (
    output rx_in,
    input  data_out,
    input  rx_valid,
    input  rx_busy,
    input  framing_err,
    input  parity_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deserializer
//  Description : UART receiver. Synchronizes rx_in, detects the start bit,
//                samples each bit at mid-bit, assembles 8 data bits LSB first
//                and reports the byte with a one-cycle rx_valid strobe plus
//                framing/parity error flags.
//                Optional feature macro: PARITY_EN (even parity bit between
//                the last data bit and the stop bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_deserializer_if.slave  bus
);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);

  // Input synchronizer and edge-detect history
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q,  prev_d;
  // Post-reset qualification: the sync flops come out of reset at 1, so the
  // first genuine samples must be seen before a 1->0 edge is trusted.
  logic [1:0]       warm_q,  warm_d;
  logic             armed_q, armed_d;

  // Frame engine
  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
`ifdef PARITY_EN
  logic             par_bit_q, par_bit_d;
`endif

  // Registered outputs
  logic [7:0]       data_out_q,    data_out_d;
  logic             rx_valid_q,    rx_valid_d;
  logic             rx_busy_q,     rx_busy_d;
  logic             framing_err_q, framing_err_d;
  logic             parity_err_q,  parity_err_d;

  logic             rx_s;
  logic             fall_edge;

  assign rx_s      = sync2_q;
  assign fall_edge = armed_q & prev_q & ~rx_s;

  // Synchronizer chain and edge-detect arming
  always_comb begin
    sync1_d = bus.rx_in;
    sync2_d = sync1_q;
    prev_d  = rx_s;
    warm_d  = {warm_q[0], 1'b1};
    armed_d = armed_q | (warm_q[1] & rx_s);
  end

  // Next-state logic for the frame engine and its registered outputs
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q + c_cnt_one;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
`ifdef PARITY_EN
    par_bit_d     = par_bit_q;
`endif
    data_out_d    = data_out_q;
    rx_valid_d    = 1'b0;
    framing_err_d = framing_err_q;
    parity_err_d  = parity_err_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (fall_edge) begin
          state_d = START;
        end
      end

      START: begin
        if (bit_cnt_q == c_half_cnt) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          // Line back high at mid start bit means a glitch, not a frame.
          state_d   = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_cnt_q == c_last_cnt) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef PARITY_EN
      PARITY: begin
        if (bit_cnt_q == c_last_cnt) begin
          bit_cnt_d = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_cnt_q == c_last_cnt) begin
          bit_cnt_d     = '0;
          state_d       = IDLE;
          rx_valid_d    = 1'b1;
          data_out_d    = shift_q;
          framing_err_d = ~rx_s;
`ifdef PARITY_EN
          parity_err_d  = (^shift_q) ^ par_bit_q;
`else
          parity_err_d  = 1'b0;
`endif
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  // State, counters and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      warm_q        <= 2'b00;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
`ifdef PARITY_EN
      par_bit_q     <= 1'b0;
`endif
      data_out_q    <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_busy_q     <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      warm_q        <= warm_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
`ifdef PARITY_EN
      par_bit_q     <= par_bit_d;
`endif
      data_out_q    <= data_out_d;
      rx_valid_q    <= rx_valid_d;
      rx_busy_q     <= rx_busy_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_busy     = rx_busy_q;
  assign bus.framing_err = framing_err_q;
  assign bus.parity_err  = parity_err_q;

endmodule
`default_nettype wire
